tdc_therm_decoder: RTL and testbench
====================================

Name: tdc_therm_decoder

Overview:
- Reads the thermometer code captured from a cascade of CARRY4 elements used as a tapped delay line (time-to-digital converter) and converts it to a binary tap count.
- Includes bubble filtering, a 4-stage fixed-latency pipeline, and a 1-entry output register with valid/ready handshake and drop accounting.
- Sits directly behind the CARRY4 chain's CO capture flops, on the consumer side of the chain.

Parameters:
- TAPS, 64, number of chain taps (CO bits); must be a multiple of 4, range 4..256.
- OUTW, derived localparam = clog2(TAPS+1), width of binary result (7 for TAPS=64).

Ports:
- C  input  1  clock, rising edge.
- CLR_N  input  1  asynchronous active-low reset.
- HIT_I  input  1  1-cycle strobe: CO_TAP is a valid sample this cycle.
- CO_TAP  input  TAPS  raw chain capture; bit 0 = first tap (nearest CI), bit 4k+j = CO[j] of CARRY4 k.
- BIN_O  output  OUTW  count of ones after bubble correction.
- VALID_O  output  1  BIN_O/OVF_O valid.
- READY_I  input  1  consumer accepts the result when VALID_O&READY_I.
- OVF_O  output  1  corrected code all ones (edge ran past chain end); qualified by VALID_O.
- DROP_O  output  1  1-cycle pulse when a result is lost.
- DROP_CNT  output  8  saturating count of dropped results.

Behaviour:
- Reset (CLR_N=0, asynchronous): all pipeline valids=0, VALID_O=0, BIN_O=0, OVF_O=0, DROP_O=0, DROP_CNT=0. Release is synchronous to C. A reset mid-pipeline discards all in-flight samples; no result for those samples ever appears.
- Pipeline advances every cycle, no backpressure into the stages; each stage carries a valid bit.
- S1 (capture): on HIT_I, register CO_TAP and set v1=1; otherwise v1=0.
- S2 (bubble filter): c[i] = majority(t[i-1], t[i], t[i+1]) with boundary values t[-1]=1 and t[TAPS]=0.
- S3 (group count): per 4-bit group, 3-bit popcount of c[4k+3:4k] (0..4).
- S4 (sum): adder tree of group counts into the OUTW-bit result r. Set ovf = (r==TAPS). Width is exact; no truncation.
- Latency: HIT_I at cycle n gives the result at the S4 output at the end of cycle n+3, and VALID_O=1 in cycle n+4 if the output register accepted it. Back-to-back hits are allowed: 1 result per cycle.
- Output register, 1 entry:
  - Loads when a result arrives and the register is empty or being accepted this cycle (VALID_O&READY_I).
  - Otherwise the arriving result is dropped: DROP_O=1 for one cycle and DROP_CNT increments, saturating at 255.
  - BIN_O/OVF_O hold stable while VALID_O=1 and READY_I=0.
  - VALID_O clears after acceptance unless it reloads in the same cycle.
- Simultaneous accept + arrival: new result loaded, VALID_O stays 1, no drop.
- Counting is popcount rather than a priority encoder, so residual non-monotonic codes still give the total ones count.
- HIT_I while CLR_N=0 is ignored.

Test Plan:
- TAPS=16, CO_TAP=0x00FF, HIT_I at cycle 0, READY_I=1 -> VALID_O=1 at cycle 4, BIN_O=8, OVF_O=0, DROP_O never asserted.
- TAPS=16, CO_TAP=0x02FF (isolated bubble at bit 9) -> BIN_O=9 (bit 8 filled, bit 9 removed). CO_TAP=0x00FB (hole at bit 2) -> BIN_O=8.
- TAPS=16, CO_TAP=0xFFFF -> BIN_O=16, OVF_O=1. CO_TAP=0x0000 -> BIN_O=0, OVF_O=0.
- Stall, TAPS=16:
  - READY_I=0, hits at cycles 0 and 1 with 0x000F and 0x00FF -> first result (BIN_O=4) held from cycle 4; second result dropped at cycle 5 with DROP_O pulse and DROP_CNT=1.
  - Raise READY_I -> one transfer of 4.
- Stream: 8 consecutive hits with READY_I=1 -> 8 results on consecutive cycles 4..11, in order, no drops. Force 300 drops -> DROP_CNT=255.
- Hits at cycles 0 and 1, CLR_N pulsed low at cycle 2 -> VALID_O stays 0 through cycle 10. All outputs read 0 during reset. A hit after release decodes normally with 4-cycle latency.

Source files
------------

// File: rtl/tdc_therm_decoder.sv
// tdc_therm_decoder
// -----------------------------------------------------------------------------
// Converts the thermometer code captured from a CARRY4 tapped delay line into a
// binary tap count. The path is a fixed four-stage pipeline followed by a
// 1-entry output register:
//   S1 capture    : register CO_TAP on HIT_I
//   S2 filter     : 3-input majority bubble filter (t[-1]=1, t[TAPS]=0)
//   S3 group count: 3-bit popcount per CARRY4 (4-bit group)
//   S4 sum        : adder tree of group counts (combinational into the
//                   output register)
// HIT_I in cycle n -> VALID_O in cycle n+4 when the output register accepts it.
//
// Handshake (output side): a result transfers on any rising edge of C where
// VALID_O=1 and READY_I=1. While VALID_O=1 and READY_I=0 the BIN_O/OVF_O
// values are held. The pipeline itself never stalls: a result that reaches
// the output register while it is full and not being drained is dropped,
// which pulses DROP_O for one cycle and bumps the saturating DROP_CNT.
//
// Ports:
//   C        clock, rising edge
//   CLR_N    asynchronous active-low reset
//   HIT_I    1-cycle strobe, CO_TAP valid this cycle
//   CO_TAP   raw chain capture, bit 4k+j = CO[j] of CARRY4 k
//   READY_I  consumer ready
//   BIN_O    count of ones after bubble correction
//   VALID_O  BIN_O/OVF_O valid
//   OVF_O    corrected code all ones (edge ran past the chain end)
//   DROP_O   1-cycle pulse when a result is lost
//   DROP_CNT saturating count of lost results
// -----------------------------------------------------------------------------
module tdc_therm_decoder #(
  parameter  int TAPS = 64,
  localparam int OUTW = $clog2(TAPS + 1)
) (
  input  logic            C,
  input  logic            CLR_N,
  input  logic            HIT_I,
  input  logic [TAPS-1:0] CO_TAP,
  input  logic            READY_I,
  output logic [OUTW-1:0] BIN_O,
  output logic            VALID_O,
  output logic            OVF_O,
  output logic            DROP_O,
  output logic [7:0]      DROP_CNT
);

  localparam int NGRP = TAPS / 4;

  // S1 capture
  logic [TAPS-1:0] t_q, t_d;
  logic            v1_q, v1_d;
  // S2 bubble filter
  logic [TAPS-1:0] c_q, c_d;
  logic            v2_q, v2_d;
  // S3 per-group counts
  logic [2:0]      grp_q [NGRP];
  logic [2:0]      grp_d [NGRP];
  logic            v3_q, v3_d;
  // S4 sum (combinational) and output register
  logic [OUTW-1:0] sum;
  logic            sum_ovf;
  logic            load, drop;
  logic            valid_q, valid_d;
  logic [OUTW-1:0] bin_q, bin_d;
  logic            ovf_q, ovf_d;
  logic            drop_q, drop_d;
  logic [7:0]      drop_cnt_q, drop_cnt_d;

  // Filter input extended with the chain boundary values: bit 0 is t[-1]=1,
  // bit TAPS+1 is t[TAPS]=0, so ext[i+1] = t[i].
  logic [TAPS+1:0] ext;

  always_comb begin
    // S1: hold the last sample when idle so the capture bank does not toggle.
    t_d  = HIT_I ? CO_TAP : t_q;
    v1_d = HIT_I;

    // S2: majority of each tap and its two neighbours.
    ext  = {1'b0, t_q, 1'b1};
    c_d  = '0;
    for (int i = 0; i < TAPS; i++) begin
      c_d[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
    end
    v2_d = v1_q;

    // S3: popcount per CARRY4 group (0..4).
    for (int k = 0; k < NGRP; k++) begin
      grp_d[k] = {2'b00, c_q[4*k]}   + {2'b00, c_q[4*k+1]}
               + {2'b00, c_q[4*k+2]} + {2'b00, c_q[4*k+3]};
    end
    v3_d = v2_q;

    // S4: sum of group counts; OUTW holds TAPS exactly so nothing is lost.
    sum = '0;
    for (int k = 0; k < NGRP; k++) begin
      sum = sum + {{(OUTW-3){1'b0}}, grp_q[k]};
    end
    sum_ovf = (sum == OUTW'(TAPS));

    // Output register: load when empty or being drained this cycle.
    load = v3_q & (~valid_q | READY_I);
    drop = v3_q & valid_q & ~READY_I;

    valid_d    = load | (valid_q & ~READY_I);
    bin_d      = load ? sum     : bin_q;
    ovf_d      = load ? sum_ovf : ovf_q;
    drop_d     = drop;
    drop_cnt_d = (drop && (drop_cnt_q != 8'hFF)) ? drop_cnt_q + 8'd1 : drop_cnt_q;
  end

  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      t_q        <= '0;
      v1_q       <= 1'b0;
      c_q        <= '0;
      v2_q       <= 1'b0;
      for (int k = 0; k < NGRP; k++) grp_q[k] <= '0;
      v3_q       <= 1'b0;
      valid_q    <= 1'b0;
      bin_q      <= '0;
      ovf_q      <= 1'b0;
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      t_q        <= t_d;
      v1_q       <= v1_d;
      c_q        <= c_d;
      v2_q       <= v2_d;
      for (int k = 0; k < NGRP; k++) grp_q[k] <= grp_d[k];
      v3_q       <= v3_d;
      valid_q    <= valid_d;
      bin_q      <= bin_d;
      ovf_q      <= ovf_d;
      drop_q     <= drop_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign BIN_O    = bin_q;
  assign VALID_O  = valid_q;
  assign OVF_O    = ovf_q;
  assign DROP_O   = drop_q;
  assign DROP_CNT = drop_cnt_q;

endmodule

// File: tb/tb_tdc_therm_decoder.sv
// Testbench for tdc_therm_decoder (TAPS=16). Directed steps from the test plan
// followed by randomized traffic, all compared every cycle against a
// behavioural model (majority filter + ones count, 1-entry output slot).
module tb_tdc_therm_decoder;

  localparam int TAPS = 16;
  localparam int OUTW = 5;

  // ---------------------------------------------------------------- clock/reset
  logic            C = 1'b0;
  logic            CLR_N;
  logic            HIT_I;
  logic [TAPS-1:0] CO_TAP;
  logic            READY_I;
  logic [OUTW-1:0] BIN_O;
  logic            VALID_O;
  logic            OVF_O;
  logic            DROP_O;
  logic [7:0]      DROP_CNT;

  always #5 C = ~C;

  tdc_therm_decoder #(.TAPS(TAPS)) dut (
    .C        (C),
    .CLR_N    (CLR_N),
    .HIT_I    (HIT_I),
    .CO_TAP   (CO_TAP),
    .READY_I  (READY_I),
    .BIN_O    (BIN_O),
    .VALID_O  (VALID_O),
    .OVF_O    (OVF_O),
    .DROP_O   (DROP_O),
    .DROP_CNT (DROP_CNT)
  );

  // ------------------------------------------------------------------- model
  typedef struct {
    bit v;
    int bin;
    bit ovf;
  } ent_t;

  int   checks   = 0;
  int   failures = 0;
  ent_t hq[$];      // results in flight, one entry per cycle
  bit   m_valid;
  int   m_bin;
  bit   m_ovf;
  bit   m_drop;
  int   m_cnt;

  // Ones count of the code after 3-tap majority with t[-1]=1, t[TAPS]=0.
  function automatic int ref_count(input logic [TAPS-1:0] co);
    int t [0:TAPS+1];
    int n;
    t[0]      = 1;
    t[TAPS+1] = 0;
    for (int i = 0; i < TAPS; i++) t[i+1] = int'(co[i]);
    n = 0;
    for (int i = 1; i <= TAPS; i++) begin
      if (t[i-1] + t[i] + t[i+1] >= 2) n++;
    end
    return n;
  endfunction

  task automatic model_reset();
    ent_t e;
    e.v = 0; e.bin = 0; e.ovf = 0;
    hq.delete();
    // A hit reaches the output register three edges after the edge that
    // captures it.
    repeat (3) hq.push_back(e);
    m_valid = 0; m_bin = 0; m_ovf = 0; m_drop = 0; m_cnt = 0;
  endtask

  // -------------------------------------------------------------- scoreboard
  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === 32'(exp)) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("valid", {31'd0, VALID_O}, int'(m_valid));
    chk("drop", {31'd0, DROP_O}, int'(m_drop));
    chk("drop_cnt", {24'd0, DROP_CNT}, m_cnt);
    if (m_valid) begin
      chk("bin", {27'd0, BIN_O}, m_bin);
      chk("ovf", {31'd0, OVF_O}, int'(m_ovf));
    end
  endtask

  // ------------------------------------------------------------------ driver
  // Inputs are set 1 time unit after a rising edge; outputs are sampled at
  // the same point, after the next edge.
  task automatic tick();
    ent_t            e, a;
    bit              h, r, rn;
    logic [TAPS-1:0] co;
    h  = HIT_I;
    r  = READY_I;
    rn = CLR_N;
    co = CO_TAP;
    @(posedge C);
    #1;
    if (!rn) begin
      model_reset();
    end else begin
      e.v   = h;
      e.bin = h ? ref_count(co) : 0;
      e.ovf = h && (e.bin == TAPS);
      hq.push_back(e);
      a = hq.pop_front();
      if (a.v) begin
        if (!m_valid || r) begin
          m_valid = 1; m_bin = a.bin; m_ovf = a.ovf; m_drop = 0;
        end else begin
          m_drop = 1;
          if (m_cnt < 255) m_cnt++;
        end
      end else begin
        m_drop = 0;
        if (r) m_valid = 0;
      end
    end
    check_all();
  endtask

  task automatic hit(input logic [TAPS-1:0] co);
    HIT_I  = 1'b1;
    CO_TAP = co;
    tick();
    HIT_I  = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, VALID_O}, 0);
    chk({tag, "_bin"}, {27'd0, BIN_O}, 0);
    chk({tag, "_ovf"}, {31'd0, OVF_O}, 0);
    chk({tag, "_drop"}, {31'd0, DROP_O}, 0);
    chk({tag, "_cnt"}, {24'd0, DROP_CNT}, 0);
  endtask

  // Leaves the bench 1 unit after a rising edge with reset released: cycle 0.
  task automatic do_reset();
    CLR_N   = 1'b0;
    HIT_I   = 1'b0;
    READY_I = 1'b0;
    CO_TAP  = '0;
    #1;
    chk_zero("rst");
    model_reset();
    @(posedge C);
    #1;
    CLR_N = 1'b1;
  endtask

  // --------------------------------------------------------------- stimulus
  initial begin
    logic [TAPS-1:0] v;
    int              len;

    // Basic decode, 4-cycle latency
    do_reset();
    READY_I = 1'b1;
    hit(16'h00FF);
    repeat (3) tick();
    chk("t1_valid", {31'd0, VALID_O}, 1);
    chk("t1_bin", {27'd0, BIN_O}, 8);
    chk("t1_ovf", {31'd0, OVF_O}, 0);

    // Bubble filtering and boundaries, back to back
    hit(16'h02FF);
    hit(16'h00FB);
    hit(16'hFFFF);
    hit(16'h0000);
    chk("bubble9_bin", {27'd0, BIN_O}, 9);
    tick();
    chk("hole2_bin", {27'd0, BIN_O}, 8);
    tick();
    chk("full_bin", {27'd0, BIN_O}, 16);
    chk("full_ovf", {31'd0, OVF_O}, 1);
    tick();
    chk("empty_bin", {27'd0, BIN_O}, 0);
    chk("empty_ovf", {31'd0, OVF_O}, 0);
    chk("empty_valid", {31'd0, VALID_O}, 1);
    tick();
    chk("t1_nodrop", {24'd0, DROP_CNT}, 0);

    // Stall: first result held, second dropped
    do_reset();
    READY_I = 1'b0;
    hit(16'h000F);
    hit(16'h00FF);
    tick(); tick();
    chk("stall_valid4", {31'd0, VALID_O}, 1);
    chk("stall_bin4", {27'd0, BIN_O}, 4);
    chk("stall_drop4", {31'd0, DROP_O}, 0);
    tick();
    chk("stall_drop5", {31'd0, DROP_O}, 1);
    chk("stall_cnt5", {24'd0, DROP_CNT}, 1);
    chk("stall_hold5", {27'd0, BIN_O}, 4);
    tick();
    chk("stall_drop6", {31'd0, DROP_O}, 0);
    chk("stall_hold6", {27'd0, BIN_O}, 4);
    READY_I = 1'b1;
    tick();
    chk("stall_xfer_done", {31'd0, VALID_O}, 0);
    chk("stall_cnt_end", {24'd0, DROP_CNT}, 1);

    // Stream of 8 hits with READY_I=1
    do_reset();
    READY_I = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c >= 4) begin
        chk("stream_valid", {31'd0, VALID_O}, 1);
        chk("stream_bin", {27'd0, BIN_O}, c - 3);
      end
      HIT_I  = (c < 8);
      CO_TAP = 16'((32'd1 << (c + 1)) - 32'd1);
      tick();
    end
    HIT_I = 1'b0;
    chk("stream_nodrop", {24'd0, DROP_CNT}, 0);

    // Drop counter saturation
    do_reset();
    READY_I = 1'b0;
    HIT_I   = 1'b1;
    for (int i = 0; i < 310; i++) begin
      CO_TAP = 16'($urandom);
      tick();
    end
    HIT_I = 1'b0;
    tick();
    chk("drop_sat", {24'd0, DROP_CNT}, 255);

    // Reset mid-pipeline discards in-flight hits; hits during reset ignored
    do_reset();
    READY_I = 1'b1;
    hit(16'h00FF);
    hit(16'h0FFF);
    CLR_N  = 1'b0;
    HIT_I  = 1'b1;
    CO_TAP = 16'h00FF;
    #1;
    chk_zero("midrst");
    model_reset();
    tick();
    chk_zero("midrst_held");
    CLR_N = 1'b1;
    HIT_I = 1'b0;
    for (int c = 3; c <= 10; c++) begin
      chk("midrst_novalid", {31'd0, VALID_O}, 0);
      tick();
    end
    hit(16'h003F);
    repeat (3) tick();
    chk("post_rst_valid", {31'd0, VALID_O}, 1);
    chk("post_rst_bin", {27'd0, BIN_O}, 6);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      HIT_I   = 1'($urandom_range(0, 1));
      READY_I = ($urandom_range(0, 3) != 0);
      len     = $urandom_range(0, TAPS);
      v       = (len == TAPS) ? '1 : 16'((32'd1 << len) - 32'd1);
      if ($urandom_range(0, 2) == 0) v = v ^ (16'd1 << $urandom_range(0, TAPS - 1));
      if ($urandom_range(0, 9) == 0) v = 16'($urandom);
      CO_TAP = v;
      tick();
    end
    HIT_I   = 1'b0;
    READY_I = 1'b1;
    repeat (6) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
